// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl_if : controller <-> datapath/memory signal bundle        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface multicycle_ctrl_if #(
  parameter int OPW   = 6,
  parameter int FNW   = 6,
  parameter int CNT_W = 32
);
  logic [OPW-1:0]   opecode;
  logic [FNW-1:0]   funct;
  logic             zflag;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic [FNW-1:0]   alu_func;
  logic             reorim;
  logic [1:0]       cp_type;
  logic             write_ir;
  logic             write_pc;
  logic             write_lr;
  logic             write_reg;
  logic             trap;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opecode, funct, zflag, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, alu_func, reorim, cp_type,
           write_ir, write_pc, write_lr, write_reg, trap, instret
  );

  modport slave (
    output opecode, funct, zflag, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, alu_func, reorim, cp_type,
           write_ir, write_pc, write_lr, write_reg, trap, instret
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl : IF/ID/EX/MEM/WB controller with decode and retire count |
// | Optional macro CTRL_ILLEGAL_TRAP_EN: unlisted opcodes trap (else NOP).   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int OPW   = 6,
  parameter int FNW   = 6,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  multicycle_ctrl_if.master  bus
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_JREG  = OPW'(6'b111111);

  localparam logic [FNW-1:0] FN_JR    = FNW'(6'b001000);
  localparam logic [FNW-1:0] ALU_ADD  = FNW'(6'b100000);
  localparam logic [FNW-1:0] ALU_SUB  = FNW'(6'b100010);
  localparam logic [FNW-1:0] ALU_AND  = FNW'(6'b100100);
  localparam logic [FNW-1:0] ALU_OR   = FNW'(6'b100101);
  localparam logic [FNW-1:0] ALU_SLT  = FNW'(6'b101010);

  localparam logic [1:0] CP_NONE = 2'b00;
  localparam logic [1:0] CP_REG  = 2'b01;
  localparam logic [1:0] CP_ABS  = 2'b10;
  localparam logic [1:0] CP_BR   = 2'b11;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [OPW-1:0] op;
  logic [FNW-1:0] fn;
  logic           is_rtype, is_lw, is_sw, is_jal, is_imm_alu, is_branch;
  logic           is_jr_r, is_alu, is_legal, enbranch;
  logic [FNW-1:0] alu_func_w;
  logic           reorim_w;
  logic [1:0]     cp_type_w;

  logic imem_req_w, dmem_req_w, dmem_we_w, trap_w;
  logic write_ir_w, write_pc_w, write_lr_w, write_reg_w;

  assign op = bus.opecode;
  assign fn = bus.funct;

  // Instruction decode: purely combinational on the latched opcode/funct.
  always_comb begin
    is_rtype   = (op == OP_RTYPE);
    is_lw      = (op == OP_LW);
    is_sw      = (op == OP_SW);
    is_jal     = (op == OP_JAL);
    is_branch  = (op == OP_BEQ) || (op == OP_BNE);
    is_imm_alu = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    is_jr_r    = is_rtype && (fn == FN_JR);
    is_alu     = (is_rtype && !is_jr_r) || is_imm_alu;
    is_legal   = is_rtype || is_imm_alu || is_branch || is_lw || is_sw ||
                 (op == OP_J) || is_jal || (op == OP_JREG);
    enbranch   = bus.zflag ^ op[0];

    alu_func_w = '0;
    if (is_rtype) begin
      alu_func_w = fn;
    end else if ((op == OP_ADDI) || is_lw || is_sw) begin
      alu_func_w = ALU_ADD;
    end else if (op == OP_ANDI) begin
      alu_func_w = ALU_AND;
    end else if (op == OP_ORI) begin
      alu_func_w = ALU_OR;
    end else if (op == OP_SLTI) begin
      alu_func_w = ALU_SLT;
    end else if (is_branch) begin
      alu_func_w = ALU_SUB;
    end

    reorim_w = is_imm_alu || is_branch || is_lw || is_sw;

    cp_type_w = CP_NONE;
    if ((op == OP_JREG) || is_jr_r) begin
      cp_type_w = CP_REG;
    end else if ((op == OP_J) || is_jal) begin
      cp_type_w = CP_ABS;
    end else if (is_branch) begin
      cp_type_w = CP_BR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IF;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Sequencer: strobes are Mealy so they fire exactly once, on the ack or EX cycle.
  always_comb begin
    state_d     = state_q;
    instret_d   = instret_q;
    imem_req_w  = 1'b0;
    dmem_req_w  = 1'b0;
    dmem_we_w   = 1'b0;
    write_ir_w  = 1'b0;
    write_pc_w  = 1'b0;
    write_lr_w  = 1'b0;
    write_reg_w = 1'b0;
    trap_w      = 1'b0;

    case (state_q)
      S_IF: begin
        imem_req_w = 1'b1;
        if (bus.imem_ack) begin
          write_ir_w = 1'b1;
          write_pc_w = 1'b1;
          state_d    = S_ID;
        end
      end
      S_ID: begin
        state_d = S_EX;
      end
      S_EX: begin
        if (cp_type_w == CP_BR) begin
          write_pc_w = enbranch;
          state_d    = S_IF;
          instret_d  = instret_q + CNT_W'(1);
        end else if (cp_type_w != CP_NONE) begin
          write_pc_w = 1'b1;
          write_lr_w = is_jal;
          state_d    = S_IF;
          instret_d  = instret_q + CNT_W'(1);
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_alu) begin
          state_d = S_WB;
        end else if (!is_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d   = S_IF;
          instret_d = instret_q + CNT_W'(1);
`endif
        end else begin
          state_d   = S_IF;
          instret_d = instret_q + CNT_W'(1);
        end
      end
      S_MEM: begin
        dmem_req_w = 1'b1;
        dmem_we_w  = is_sw;
        if (bus.dmem_ack) begin
          if (is_sw) begin
            state_d   = S_IF;
            instret_d = instret_q + CNT_W'(1);
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        write_reg_w = 1'b1;
        state_d     = S_IF;
        instret_d   = instret_q + CNT_W'(1);
      end
      S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap_w = 1'b1;
`else
        state_d = S_IF;
`endif
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Every output is forced low while reset is held, including the counter.
  assign bus.imem_req  = rstn & imem_req_w;
  assign bus.dmem_req  = rstn & dmem_req_w;
  assign bus.dmem_we   = rstn & dmem_we_w;
  assign bus.write_ir  = rstn & write_ir_w;
  assign bus.write_pc  = rstn & write_pc_w;
  assign bus.write_lr  = rstn & write_lr_w;
  assign bus.write_reg = rstn & write_reg_w;
  assign bus.trap      = rstn & trap_w;
  assign bus.reorim    = rstn & reorim_w;
  assign bus.alu_func  = rstn ? alu_func_w : '0;
  assign bus.cp_type   = rstn ? cp_type_w  : 2'b00;
  assign bus.instret   = rstn ? instret_q  : '0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_ctrl : scoreboard bench, directed instruction vectors      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  localparam int OPW   = 6;
  localparam int FNW   = 6;
  localparam int CNT_W = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OPW(OPW), .FNW(FNW), .CNT_W(CNT_W)) bus ();
  multicycle_ctrl #(.OPW(OPW), .FNW(FNW), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // stb = {write_ir, write_pc, write_lr, write_reg, dmem done, dmem_we}
  // dv  = {alu_func, reorim, cp_type}
  typedef struct packed {
    logic [5:0] stb;
    logic       dec;
    logic [8:0] dv;
  } ev_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [3:0] iw;
    logic [3:0] dw;
    logic [5:0] alu;
    logic       ri;
    logic [1:0] cp;
    logic       xpc;
    logic       xlr;
    logic [1:0] mem;
    logic       wb;
    logic [7:0] cyc;
  } vec_t;

  ev_t  q[$];
  vec_t vecs [0:15];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe or completed data access must match the queue head.
  initial begin
    ev_t e;
    logic [5:0] a_stb;
    forever begin
      @(negedge clk);
      a_stb = {bus.write_ir, bus.write_pc, bus.write_lr, bus.write_reg,
               bus.dmem_req & bus.dmem_ack, bus.dmem_we};
      if (rstn && (a_stb[5:1] != 5'b0)) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got stb %b expected none", a_stb);
        end else begin
          e = q.pop_front();
          chk("event_strobes", 64'(a_stb), 64'(e.stb));
          if (e.dec) chk("event_decode", 64'({bus.alu_func, bus.reorim, bus.cp_type}), 64'(e.dv));
        end
      end
    end
  end

  task automatic exec(input vec_t v);
    int cyc, dcnt, guard;
    bus.opecode = v.op;
    bus.funct   = v.fn;
    bus.zflag   = v.z;
    q.push_back('{stb: 6'b110000, dec: 1'b0, dv: 9'b0});
    if (v.xpc)     q.push_back('{stb: {2'b01, v.xlr, 3'b000}, dec: 1'b1, dv: {v.alu, v.ri, v.cp}});
    if (v.mem != 0) q.push_back('{stb: {4'b0000, 1'b1, v.mem == 2'd2}, dec: 1'b1, dv: {v.alu, v.ri, v.cp}});
    if (v.wb)      q.push_back('{stb: 6'b000100, dec: 1'b1, dv: {v.alu, v.ri, v.cp}});
    cyc = 0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < int'(v.iw); i++) begin
      tick();
      cyc++;
    end
    bus.imem_ack = 1'b1;
    tick();
    cyc++;
    chk("decode_id", 64'({bus.alu_func, bus.reorim, bus.cp_type}), 64'({v.alu, v.ri, v.cp}));
    dcnt  = 0;
    guard = 0;
    while (!bus.imem_req && guard < 40) begin
      if (bus.dmem_req) begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = (dcnt == int'(v.dw));
        dcnt++;
      end else begin
        // stray acks outside the matching wait state
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
      end
      tick();
      cyc++;
      guard++;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    chk("if_to_if_cycles", 64'(cyc), 64'(v.cyc));
    if (v.mem != 0) chk("dmem_req_hold", 64'(dcnt), 64'(v.dw) + 64'd1);
    exp_ret = exp_ret + 1'b1;
    chk("instret", 64'(bus.instret), 64'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               op         fn         z  iw  dw  alu        ri cp     pc lr mem   wb cyc
    vecs[0]  = '{6'b001000, 6'b000000, 1'b0, 4'd3, 4'd0, 6'b100000, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, 8'd7};
    vecs[1]  = '{6'b000100, 6'b000000, 1'b1, 4'd0, 4'd0, 6'b100010, 1'b1, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 8'd3};
    vecs[2]  = '{6'b000101, 6'b000000, 1'b1, 4'd1, 4'd0, 6'b100010, 1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 8'd4};
    vecs[3]  = '{6'b100011, 6'b000000, 1'b0, 4'd0, 4'd2, 6'b100000, 1'b1, 2'b00, 1'b0, 1'b0, 2'd1, 1'b1, 8'd7};
    vecs[4]  = '{6'b101011, 6'b000000, 1'b0, 4'd1, 4'd2, 6'b100000, 1'b1, 2'b00, 1'b0, 1'b0, 2'd2, 1'b0, 8'd7};
    vecs[5]  = '{6'b000011, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b000000, 1'b0, 2'b10, 1'b1, 1'b1, 2'd0, 1'b0, 8'd3};
    vecs[6]  = '{6'b000000, 6'b001000, 1'b0, 4'd0, 4'd0, 6'b001000, 1'b0, 2'b01, 1'b1, 1'b0, 2'd0, 1'b0, 8'd3};
    vecs[7]  = '{6'b000000, 6'b100000, 1'b0, 4'd2, 4'd0, 6'b100000, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, 8'd6};
    vecs[8]  = '{6'b001100, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b100100, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, 8'd4};
    vecs[9]  = '{6'b001101, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b100101, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, 8'd4};
    vecs[10] = '{6'b001010, 6'b000000, 1'b0, 4'd1, 4'd0, 6'b101010, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, 8'd5};
    vecs[11] = '{6'b000010, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b000000, 1'b0, 2'b10, 1'b1, 1'b0, 2'd0, 1'b0, 8'd3};
    vecs[12] = '{6'b000100, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b100010, 1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 8'd3};
    vecs[13] = '{6'b111111, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b000000, 1'b0, 2'b01, 1'b1, 1'b0, 2'd0, 1'b0, 8'd3};
    vecs[14] = '{6'b100011, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b100000, 1'b1, 2'b00, 1'b0, 1'b0, 2'd1, 1'b1, 8'd5};
    vecs[15] = '{6'b000101, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b100010, 1'b1, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 8'd3};

    // Reset with a jump opcode and a pending ack present: all outputs must stay 0.
    bus.opecode  = 6'b000010;
    bus.funct    = 6'b000000;
    bus.zflag    = 1'b1;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_outputs", 64'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.alu_func, bus.reorim,
          bus.cp_type, bus.write_ir, bus.write_pc, bus.write_lr, bus.write_reg, bus.trap, bus.instret}), 64'd0);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    rstn = 1'b1;
    tick();
    chk("imem_req_after_reset", 64'(bus.imem_req), 64'd1);
    chk("instret_after_reset", 64'(bus.instret), 64'd0);

    // 16 instructions on a 4-bit counter: the last one wraps instret to 0.
    for (int i = 0; i < 16; i++) exec(vecs[i]);

`ifdef CTRL_ILLEGAL_TRAP_EN
    bus.opecode = 6'b110011;
    bus.funct   = 6'b000000;
    q.push_back('{stb: 6'b110000, dec: 1'b0, dv: 9'b0});
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("trap_sticky", 64'({bus.trap, bus.imem_req, bus.instret}), 64'({1'b1, 1'b0, exp_ret}));
      bus.imem_ack = 1'b1;
      tick();
    end
    bus.imem_ack = 1'b0;
    rstn = 1'b0;
    tick();
    chk("trap_in_reset", 64'({bus.trap, bus.imem_req}), 64'd0);
    rstn = 1'b1;
    tick();
    chk("trap_cleared", 64'({bus.trap, bus.imem_req, bus.instret}), 64'({1'b0, 1'b1, 4'd0}));
`else
    exec('{6'b110011, 6'b000000, 1'b0, 4'd0, 4'd0, 6'b000000, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 8'd3});
    chk("nop_no_trap", 64'(bus.trap), 64'd0);
`endif

    tick();
    tick();
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL events_outstanding: got %0d expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
